register_file_dual_write: RTL and testbench

Parametrised successor to the single-write register file. Provides 3 combinational read ports and 2 synchronous write ports: port 0 for the ALU result and port 1 for load return. Also holds a per-register busy scoreboard with a busy counter, so the control unit can stall on registers whose pending loads have not yet returned. Sits in the decode/writeback stage of the pipelined datapath.

---
 rtl/register_file_dual_write.sv | 119 +++++++++++
 tb/tb_register_file_dual_write.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/register_file_dual_write.sv
// Register file with three combinational read ports, two write ports (port 1 wins) and a load busy scoreboard.
// Optional macro REGFILE_BYPASS_EN: read ports forward same-cycle write data (write-first).
module register_file_dual_write #(
    parameter int W         = 16,
    parameter int ADDR_BITS = 4,
    parameter int NUM_REGS  = 16
) (
    input  logic                 clk,
    input  logic                 reset_asynchronous,
    input  logic                 write_enable0,
    input  logic [ADDR_BITS-1:0] inp_write_address0,
    input  logic [W-1:0]         inp_write_data0,
    input  logic                 write_enable1,
    input  logic [ADDR_BITS-1:0] inp_write_address1,
    input  logic [W-1:0]         inp_write_data1,
    input  logic                 mark_busy,
    input  logic [ADDR_BITS-1:0] inp_mark_address,
    input  logic [ADDR_BITS-1:0] inp_read_address0,
    input  logic [ADDR_BITS-1:0] inp_read_address1,
    input  logic [ADDR_BITS-1:0] inp_read_address2,
    output logic [W-1:0]         out_read_data0,
    output logic [W-1:0]         out_read_data1,
    output logic [W-1:0]         out_read_data2,
    output logic                 out_busy0,
    output logic                 out_busy1,
    output logic                 out_busy2,
    output logic [ADDR_BITS:0]   out_busy_count
);

    logic [W-1:0]         regs_r [NUM_REGS];
    logic [NUM_REGS-1:0]  busy_r;
    logic [ADDR_BITS:0]   busy_count_r;

    logic [NUM_REGS-1:0]  wr0_hit_s;
    logic [NUM_REGS-1:0]  wr1_hit_s;
    logic [NUM_REGS-1:0]  set_hit_s;
    logic [NUM_REGS-1:0]  busy_next_s;
    logic                 inc_s;
    logic                 dec_s;
    logic [ADDR_BITS-1:0] rd_addr_s [3];
    logic [W-1:0]         rd_data_s [3];
    logic                 rd_busy_s [3];

    assign rd_addr_s[0] = inp_read_address0;
    assign rd_addr_s[1] = inp_read_address1;
    assign rd_addr_s[2] = inp_read_address2;

    // Per-register decode; addresses >= NUM_REGS match nothing, so they are ignored everywhere
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            wr0_hit_s[i] = write_enable0 && (inp_write_address0 == ADDR_BITS'(i));
            wr1_hit_s[i] = write_enable1 && (inp_write_address1 == ADDR_BITS'(i));
            set_hit_s[i] = mark_busy && (inp_mark_address == ADDR_BITS'(i));
        end
    end

    // Scoreboard next state: a set beats a clear on the same register
    always_comb begin
        busy_next_s = set_hit_s | (busy_r & ~wr1_hit_s);
        inc_s       = |(set_hit_s & ~busy_r);
        dec_s       = |(wr1_hit_s & busy_r & ~set_hit_s);
    end

    // Storage array update, port 1 overriding port 0 on a shared address
    always_ff @(posedge clk or posedge reset_asynchronous) begin
        if (reset_asynchronous) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= {W{1'b0}};
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr1_hit_s[i]) begin
                    regs_r[i] <= inp_write_data1;
                end else if (wr0_hit_s[i]) begin
                    regs_r[i] <= inp_write_data0;
                end
            end
        end
    end

    // Scoreboard bits and busy counter; set and clear happen on different registers at most once each
    always_ff @(posedge clk or posedge reset_asynchronous) begin
        if (reset_asynchronous) begin
            busy_r       <= {NUM_REGS{1'b0}};
            busy_count_r <= {(ADDR_BITS+1){1'b0}};
        end else begin
            busy_r       <= busy_next_s;
            busy_count_r <= busy_count_r + {{ADDR_BITS{1'b0}}, inc_s} - {{ADDR_BITS{1'b0}}, dec_s};
        end
    end

    // Read muxes; busy status never forwards same-cycle marks or clears
    always_comb begin
        for (int p = 0; p < 3; p++) begin
            rd_data_s[p] = {W{1'b0}};
            rd_busy_s[p] = 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                rd_data_s[p] = (rd_addr_s[p] == ADDR_BITS'(i)) ? regs_r[i] : rd_data_s[p];
                rd_busy_s[p] = (rd_addr_s[p] == ADDR_BITS'(i)) ? busy_r[i] : rd_busy_s[p];
            end
`ifdef REGFILE_BYPASS_EN
            // |hit guarantees the write is enabled and in range; port 1 applied last so it wins
            rd_data_s[p] = ((|wr0_hit_s) && (rd_addr_s[p] == inp_write_address0)) ? inp_write_data0 : rd_data_s[p];
            rd_data_s[p] = ((|wr1_hit_s) && (rd_addr_s[p] == inp_write_address1)) ? inp_write_data1 : rd_data_s[p];
`else
            rd_data_s[p] = rd_data_s[p];
`endif
        end
    end

    assign out_read_data0 = rd_data_s[0];
    assign out_read_data1 = rd_data_s[1];
    assign out_read_data2 = rd_data_s[2];
    assign out_busy0      = rd_busy_s[0];
    assign out_busy1      = rd_busy_s[1];
    assign out_busy2      = rd_busy_s[2];
    assign out_busy_count = busy_count_r;

endmodule

// File: tb/tb_register_file_dual_write.sv
// Directed self-checking bench for register_file_dual_write (default parameters).
module tb_register_file_dual_write;

    logic        clk = 1'b0;
    logic        reset_asynchronous;
    logic        write_enable0, write_enable1, mark_busy;
    logic [3:0]  inp_write_address0, inp_write_address1, inp_mark_address;
    logic [15:0] inp_write_data0, inp_write_data1;
    logic [3:0]  inp_read_address0, inp_read_address1, inp_read_address2;
    logic [15:0] out_read_data0, out_read_data1, out_read_data2;
    logic        out_busy0, out_busy1, out_busy2;
    logic [4:0]  out_busy_count;

    int checks = 0;
    int errors = 0;

    register_file_dual_write dut (
        .clk(clk), .reset_asynchronous(reset_asynchronous),
        .write_enable0(write_enable0), .inp_write_address0(inp_write_address0), .inp_write_data0(inp_write_data0),
        .write_enable1(write_enable1), .inp_write_address1(inp_write_address1), .inp_write_data1(inp_write_data1),
        .mark_busy(mark_busy), .inp_mark_address(inp_mark_address),
        .inp_read_address0(inp_read_address0), .inp_read_address1(inp_read_address1), .inp_read_address2(inp_read_address2),
        .out_read_data0(out_read_data0), .out_read_data1(out_read_data1), .out_read_data2(out_read_data2),
        .out_busy0(out_busy0), .out_busy1(out_busy1), .out_busy2(out_busy2),
        .out_busy_count(out_busy_count)
    );

    always #5 clk = ~clk;

    task automatic idle();
        write_enable0 = 1'b0; write_enable1 = 1'b0; mark_busy = 1'b0;
        inp_write_address0 = 4'd0; inp_write_address1 = 4'd0; inp_mark_address = 4'd0;
        inp_write_data0 = 16'h0000; inp_write_data1 = 16'h0000;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        reset_asynchronous = 1'b1;
        #2;
        reset_asynchronous = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        idle();
        reset_asynchronous = 1'b0;
        tick();
        write_enable0 = 1'b1; inp_write_address0 = 4'd1; inp_write_data0 = 16'h0055;
        mark_busy = 1'b1; inp_mark_address = 4'd1;
        tick();
        idle();
        reset_asynchronous = 1'b1;
        #1;
        for (int a = 0; a < 16; a++) begin
            inp_read_address0 = 4'(a);
            #1;
            checks++;
            if (out_read_data0 !== 16'h0000) begin
                errors++;
                $display("FAIL reset_read addr %0d got %h want 0000", a, out_read_data0);
            end
        end
        inp_read_address0 = 4'd1;
        #1;
        checks++;
        if (out_busy_count !== 5'd0 || out_busy0 !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy got count %0d busy %b want 0 0", out_busy_count, out_busy0);
        end
        reset_asynchronous = 1'b0;
        #1;
    endtask

    task automatic test_dual_write();
        idle();
        write_enable0 = 1'b1; inp_write_address0 = 4'd2; inp_write_data0 = 16'h1234;
        write_enable1 = 1'b1; inp_write_address1 = 4'd5; inp_write_data1 = 16'hABCD;
        tick();
        idle();
        inp_read_address1 = 4'd2; inp_read_address2 = 4'd5;
        #1;
        checks++;
        if (out_read_data1 !== 16'h1234) begin
            errors++;
            $display("FAIL dual_write_r2 got %h want 1234", out_read_data1);
        end
        checks++;
        if (out_read_data2 !== 16'hABCD) begin
            errors++;
            $display("FAIL dual_write_r5 got %h want abcd", out_read_data2);
        end
    endtask

    task automatic test_collision();
        idle();
        write_enable0 = 1'b1; inp_write_address0 = 4'd7; inp_write_data0 = 16'h1111;
        write_enable1 = 1'b1; inp_write_address1 = 4'd7; inp_write_data1 = 16'h2222;
        tick();
        idle();
        inp_read_address0 = 4'd7;
        #1;
        checks++;
        if (out_read_data0 !== 16'h2222) begin
            errors++;
            $display("FAIL collision_r7 got %h want 2222", out_read_data0);
        end
    endtask

    task automatic test_bypass();
        logic [15:0] same_cycle_exp;
`ifdef REGFILE_BYPASS_EN
        same_cycle_exp = 16'h9876;
`else
        same_cycle_exp = 16'h0000;
`endif
        idle();
        write_enable0 = 1'b1; inp_write_address0 = 4'd3; inp_write_data0 = 16'h9876;
        inp_read_address0 = 4'd3;
        #1;
        checks++;
        if (out_read_data0 !== same_cycle_exp) begin
            errors++;
            $display("FAIL bypass_same_cycle got %h want %h", out_read_data0, same_cycle_exp);
        end
        tick();
        idle();
        #1;
        checks++;
        if (out_read_data0 !== 16'h9876) begin
            errors++;
            $display("FAIL bypass_after_edge got %h want 9876", out_read_data0);
        end
    endtask

    task automatic test_scoreboard();
        idle();
        pulse_reset();
        inp_read_address0 = 4'd4; inp_read_address1 = 4'd9; inp_read_address2 = 4'd6;
        mark_busy = 1'b1; inp_mark_address = 4'd4;
        #1;
        checks++;
        if (out_busy0 !== 1'b0) begin
            errors++;
            $display("FAIL busy_no_forward got %b want 0", out_busy0);
        end
        tick();
        checks++;
        if (out_busy_count !== 5'd1) begin
            errors++;
            $display("FAIL mark_r4_count got %0d want 1", out_busy_count);
        end
        inp_mark_address = 4'd9;
        tick();
        checks++;
        if (out_busy_count !== 5'd2 || out_busy0 !== 1'b1 || out_busy1 !== 1'b1) begin
            errors++;
            $display("FAIL mark_r9 got count %0d b4 %b b9 %b want 2 1 1", out_busy_count, out_busy0, out_busy1);
        end
        idle();
        write_enable0 = 1'b1; inp_write_address0 = 4'd4; inp_write_data0 = 16'h0BAD;
        tick();
        checks++;
        if (out_busy0 !== 1'b1 || out_busy_count !== 5'd2 || out_read_data0 !== 16'h0BAD) begin
            errors++;
            $display("FAIL port0_no_clear got b4 %b count %0d r4 %h want 1 2 0bad", out_busy0, out_busy_count, out_read_data0);
        end
        idle();
        write_enable1 = 1'b1; inp_write_address1 = 4'd4; inp_write_data1 = 16'h0007;
        tick();
        idle();
        #1;
        checks++;
        if (out_busy0 !== 1'b0 || out_busy_count !== 5'd1 || out_read_data0 !== 16'h0007) begin
            errors++;
            $display("FAIL port1_clear got b4 %b count %0d r4 %h want 0 1 0007", out_busy0, out_busy_count, out_read_data0);
        end
    endtask

    task automatic test_simultaneous();
        idle();
        mark_busy = 1'b1; inp_mark_address = 4'd6;
        write_enable1 = 1'b1; inp_write_address1 = 4'd6; inp_write_data1 = 16'h0066;
        tick();
        checks++;
        if (out_busy2 !== 1'b1 || out_busy_count !== 5'd2) begin
            errors++;
            $display("FAIL set_clear_same got b6 %b count %0d want 1 2", out_busy2, out_busy_count);
        end
        inp_mark_address = 4'd8; inp_write_address1 = 4'd9;
        tick();
        inp_read_address0 = 4'd8;
        #1;
        checks++;
        if (out_busy_count !== 5'd2 || out_busy1 !== 1'b0 || out_busy0 !== 1'b1) begin
            errors++;
            $display("FAIL set_clear_diff got count %0d b9 %b b8 %b want 2 0 1", out_busy_count, out_busy1, out_busy0);
        end
        idle();
        mark_busy = 1'b1; inp_mark_address = 4'd8;
        tick();
        checks++;
        if (out_busy_count !== 5'd2 || out_busy0 !== 1'b1) begin
            errors++;
            $display("FAIL remark got count %0d b8 %b want 2 1", out_busy_count, out_busy0);
        end
        idle();
        write_enable1 = 1'b1; inp_write_address1 = 4'd12;
        tick();
        checks++;
        if (out_busy_count !== 5'd2) begin
            errors++;
            $display("FAIL clear_idle_bit got count %0d want 2", out_busy_count);
        end
    endtask

    task automatic test_reset_mid();
        idle();
        mark_busy = 1'b1; inp_mark_address = 4'd10;
        tick();
        checks++;
        if (out_busy_count !== 5'd3) begin
            errors++;
            $display("FAIL pre_reset_count got %0d want 3", out_busy_count);
        end
        mark_busy = 1'b1; inp_mark_address = 4'd11;
        write_enable1 = 1'b1; inp_write_address1 = 4'd6; inp_write_data1 = 16'hDEAD;
        reset_asynchronous = 1'b1;
        tick();
        idle();
        reset_asynchronous = 1'b0;
        inp_read_address0 = 4'd6; inp_read_address1 = 4'd11; inp_read_address2 = 4'd8;
        #1;
        checks++;
        if (out_busy_count !== 5'd0 || out_busy1 !== 1'b0 || out_busy2 !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_busy got count %0d b11 %b b8 %b want 0 0 0", out_busy_count, out_busy1, out_busy2);
        end
        checks++;
        if (out_read_data0 !== 16'h0000) begin
            errors++;
            $display("FAIL reset_mid_data got %h want 0000", out_read_data0);
        end
        tick();
        checks++;
        if (out_busy_count !== 5'd0 || out_read_data0 !== 16'h0000) begin
            errors++;
            $display("FAIL reset_mid_idle_edge got count %0d r6 %h want 0 0000", out_busy_count, out_read_data0);
        end
    endtask

    initial begin
        reset_asynchronous = 1'b1;
        inp_read_address0 = 4'd0; inp_read_address1 = 4'd0; inp_read_address2 = 4'd0;
        idle();
        #12;
        test_reset();
        test_dual_write();
        test_collision();
        test_bypass();
        test_scoreboard();
        test_simultaneous();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
